stop_watch_ndig: RTL and testbench

//   Parametrised N-digit BCD stopwatch: up/down counting, pause, synchronous clear, preset load.

---
 rtl/stop_watch_ndig.sv | 143 ++++++++++++++
 tb/tb_stop_watch_ndig.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stop_watch_ndig.sv
// Parametrised N-digit BCD stopwatch with prescaler, up/down count,
// pause, clear, preset load, wrap/done events and optional lap capture.
//
// Ports:
//   clk, reset_n   clock (rising edge), async active-low reset
//   go             level: 1 = run, 0 = pause (prescaler and digits hold)
//   clr            sync pulse: digits, prescaler (and lap) to 0
//   up             count direction, 1 = up, 0 = down
//   load, load_val sync preset; nibbles above 9 are clamped to 9
//   lap            sync pulse: capture current digits into lap_digits
//   digits         current BCD count, digit 0 = least significant
//   lap_digits     captured lap value (0 when the lap feature is off)
//   tick           1-cycle pulse on every applied count step
//   wrap           1-cycle pulse on up-count all-9s -> all-0s
//   done           1-cycle pulse when a down-count reaches all-0s
//   running        registered copy of go
//
// Define LAP_EN to build the lap register; otherwise lap is ignored.
module stop_watch_ndig #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 5000000,
    parameter int PW       = 23
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  go,
    input  logic                  clr,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   digits,
    output logic [4*DIGITS-1:0]   lap_digits,
    output logic                  tick,
    output logic                  wrap,
    output logic                  done,
    output logic                  running
);

    localparam int W = 4 * DIGITS;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          ps_last;
    logic [W-1:0]  inc_val;
    logic [W-1:0]  dec_val;
    logic [W-1:0]  clamp_val;
    logic          carry;
    logic          borrow;
    logic          all_nine;
    logic          all_zero;

    assign ps_last = (presc == PS_LAST);

    // Ripple increment/decrement across the BCD digits. A carry that
    // survives every digit means the value was all 9s; likewise a
    // surviving borrow means the value was all 0s.
    always_comb begin
        inc_val   = digits;
        dec_val   = digits;
        clamp_val = load_val;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (digits[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = digits[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (digits[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = digits[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > 4'd9) begin
                clamp_val[4*i +: 4] = 4'd9;
            end
        end
        all_nine = carry;
        all_zero = borrow;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc   <= '0;
            digits  <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
            running <= 1'b0;
        end else begin
            tick    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
            running <= go;
            if (clr) begin
                digits <= '0;
                presc  <= '0;
            end else if (load) begin
                digits <= clamp_val;
                presc  <= '0;
            end else if (go) begin
                presc <= ps_last ? '0 : presc + PW'(1);
                if (ps_last) begin
                    if (up) begin
                        digits <= inc_val;
                        tick   <= 1'b1;
                        wrap   <= all_nine;
                    end else if (!all_zero) begin
                        // Saturate at zero: no step is applied there,
                        // while the prescaler keeps cycling.
                        digits <= dec_val;
                        tick   <= 1'b1;
                        done   <= (dec_val == '0);
                    end
                end
            end
        end
    end

`ifdef LAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_digits <= '0;
        end else if (clr) begin
            lap_digits <= '0;
        end else if (lap) begin
            lap_digits <= digits;
        end
    end
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign lap_digits = '0;
`endif

endmodule

// File: tb/tb_stop_watch_ndig.sv
// Scoreboard bench for stop_watch_ndig (DIGITS=4, TICK_DIV=4): a decimal
// reference model predicts each cycle, a monitor pops and compares.
module tb_stop_watch_ndig;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go = 1'b0;
    logic        clr = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic        lap = 1'b0;
    logic [15:0] digits;
    logic [15:0] lap_digits;
    logic        tick;
    logic        wrap;
    logic        done;
    logic        running;

    stop_watch_ndig #(.DIGITS(4), .TICK_DIV(TD), .PW(3)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .clr(clr), .up(up),
        .load(load), .load_val(load_val), .lap(lap),
        .digits(digits), .lap_digits(lap_digits), .tick(tick),
        .wrap(wrap), .done(done), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [15:0] lp;
        logic        tk;
        logic        wr;
        logic        dn;
        logic        run;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err = 0;
    logic rst_cmd = 1'b0;

    // Reference model state: plain decimal value and prescaler count.
    int   m_val = 0;
    int   m_ps = 0;
    int   m_lap = 0;
    logic m_run = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamped(input logic [15:0] b);
        int v;
        int m;
        int n;
        v = 0;
        m = 1;
        for (int i = 0; i < 4; i++) begin
            n = int'(b[4*i +: 4]);
            if (n > 9) n = 9;
            v = v + n * m;
            m = m * 10;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_step(output exp_t e);
        e.tk = 1'b0;
        e.wr = 1'b0;
        e.dn = 1'b0;
        if (!reset_n) begin
            m_val = 0;
            m_ps = 0;
            m_lap = 0;
            m_run = 1'b0;
        end else begin
`ifdef LAP_EN
            if (clr) m_lap = 0;
            else if (lap) m_lap = m_val;
`endif
            m_run = go;
            if (clr) begin
                m_val = 0;
                m_ps = 0;
            end else if (load) begin
                m_val = from_bcd_clamped(load_val);
                m_ps = 0;
            end else if (go) begin
                if (m_ps == TD - 1) begin
                    m_ps = 0;
                    if (up) begin
                        e.tk = 1'b1;
                        if (m_val == 9999) begin
                            m_val = 0;
                            e.wr = 1'b1;
                        end else begin
                            m_val = m_val + 1;
                        end
                    end else if (m_val > 0) begin
                        e.tk = 1'b1;
                        m_val = m_val - 1;
                        e.dn = (m_val == 0);
                    end
                end else begin
                    m_ps = m_ps + 1;
                end
            end
        end
        e.d = to_bcd(m_val);
        e.lp = to_bcd(m_lap);
        e.run = m_run;
    endtask

    task automatic drive(input logic g, input logic u, input logic c,
                         input logic l, input logic lp,
                         input logic [15:0] lv);
        exp_t e;
        @(negedge clk);
        reset_n = rst_cmd;
        go = g;
        up = u;
        clr = c;
        load = l;
        lap = lp;
        load_val = lv;
        model_step(e);
        q.push_back(e);
    endtask

    task automatic run(input int n, input logic g, input logic u);
        for (int i = 0; i < n; i++) drive(g, u, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("digits", digits, e.d);
            chk("lap_digits", lap_digits, e.lp);
            chk("tick", {15'd0, tick}, {15'd0, e.tk});
            chk("wrap", {15'd0, wrap}, {15'd0, e.wr});
            chk("done", {15'd0, done}, {15'd0, e.dn});
            chk("running", {15'd0, running}, {15'd0, e.run});
        end
    end

    initial begin
        int v;
        // reset state, then free counting up
        rst_cmd = 1'b0;
        run(2, 1'b1, 1'b1);
        rst_cmd = 1'b1;
        run(44, 1'b1, 1'b1);
        // wrap from all 9s
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h9998);
        run(10, 1'b1, 1'b1);
        // countdown to zero and saturate
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0002);
        run(20, 1'b1, 1'b0);
        // pause/resume keeps prescaler phase
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        run(2, 1'b1, 1'b1);
        run(10, 1'b0, 1'b1);
        run(8, 1'b1, 1'b1);
        // clr beats load; clamped preset
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h12F4);
        run(2, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        chk("clamp_load", digits, 16'h1294);
        // lap capture
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0055);
        run(8, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        run(6, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0321);
        run(5, 1'b1, 1'b1);
        // async reset between edges
        @(posedge clk);
        #2;
        rst_cmd = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_digits", digits, 16'h0);
        chk("async_running", {15'd0, running}, 16'h0);
        chk("async_lap", lap_digits, 16'h0);
        run(2, 1'b1, 1'b1);
        rst_cmd = 1'b1;
        run(10, 1'b1, 1'b1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic g;
            logic u;
            logic c;
            logic l;
            logic lp;
            logic [15:0] lv;
            g = ($urandom_range(0, 9) != 0);
            u = ($urandom_range(0, 1) != 0);
            c = ($urandom_range(0, 199) == 0);
            l = ($urandom_range(0, 39) == 0);
            lp = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0: begin
                    v = 9990 + int'($urandom_range(0, 9));
                    lv = to_bcd(v);
                end
                1: begin
                    v = int'($urandom_range(0, 9));
                    lv = to_bcd(v);
                end
                default: lv = 16'($urandom);
            endcase
            drive(g, u, c, l, lp, lv);
        end
        @(posedge clk);
        #2;
        chk("queue_drained", 16'(q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
